// File: rtl/serial_frame_ctrl.sv
// Start-bit-aligned serial frame receiver that drops bad frames and queues good ones for a valid/ready consumer.
// Latency: a good frame reaches msg_valid/msg_data 1 clock after its stop-bit strobe.
// Backpressure: the FIFO fills while msg_ready is low; a good frame arriving when it is full is dropped and overrun pulses.
module serial_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int ODD_PARITY = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  serial_in,
    input  logic                  bit_valid,
    output logic [DATA_WIDTH-1:0] msg_data,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic                  busy,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [BW-1:0]           bit_cnt;
    logic                    parity_bit;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;

    logic stop_evt, parity_ok, good, full, push, pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bit_valid) begin
            case (state)
                IDLE:    if (!serial_in) state_nxt = DATA;
                DATA:    if (bit_cnt == LAST_BIT) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
        end else if (bit_valid) begin
            case (state)
                IDLE:    if (!serial_in) bit_cnt <= '0;
                DATA: begin
                    // LSB arrives first, so each new bit enters at the top and walks down.
                    shift_reg <= {serial_in, shift_reg[DATA_WIDTH-1:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                PARITY:  parity_bit <= serial_in;
                default: ;
            endcase
        end
    end

    assign stop_evt  = (state == STOP) && bit_valid;
    assign parity_ok = (PARITY_EN == 0) || (((^shift_reg) ^ parity_bit) == 1'(ODD_PARITY));
    assign good      = stop_evt && serial_in && parity_ok;
    assign full      = (count == FULL_CNT);
    assign pop       = msg_valid && msg_ready;
    // A simultaneous pop frees the head slot, so a full FIFO can still take the frame.
    assign push      = good && (!full || pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= stop_evt && !serial_in;
            parity_err <= stop_evt && serial_in && !parity_ok;
            overrun    <= good && full && !pop;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign msg_valid = (count != '0);
    assign msg_data  = msg_valid ? mem[rd_ptr] : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl: expected messages are queued as frames are sent and checked as they pop.
module tb_serial_frame_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       bit_valid;
    logic [7:0] msg_data;
    logic       msg_valid;
    logic       msg_ready;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    serial_frame_ctrl #(
        .DATA_WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0), .FIFO_DEPTH(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes seen here complete on the following rising edge.
    always begin
        @(negedge clock);
        #1;
        if (reset_n && msg_valid && msg_ready) begin
            check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check_val("msg_data", 32'(msg_data), 32'(sb_q.pop_front()));
        end
    end

    task automatic send_bit(input logic b, input int gap);
        @(negedge clock);
        serial_in = b;
        bit_valid = 1'b1;
        @(negedge clock);
        bit_valid = 1'b0;
        serial_in = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    // Returns on the falling edge right after the stop-bit strobe edge.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b,
                              input int gap, input logic rdy_pulse);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit((^d) ^ bad_par, gap);
        @(negedge clock);
        serial_in = stop_b;
        bit_valid = 1'b1;
        if (rdy_pulse) msg_ready = 1'b1;
        @(negedge clock);
        bit_valid = 1'b0;
        serial_in = 1'b1;
        if (rdy_pulse) msg_ready = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clock);
        end
        repeat (2) @(negedge clock);
        #1;
        check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check_val({tag, "_valid_low"}, 32'(msg_valid), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        serial_in = 1'b1;
        bit_valid = 1'b0;
        msg_ready = 1'b1;
        #2;
        check_val("rst_valid", 32'(msg_valid), 32'd0);
        check_val("rst_data", 32'(msg_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1: good frame, immediate delivery
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        #1;
        check_val("t1_valid", 32'(msg_valid), 32'd1);
        check_val("t1_data", 32'(msg_data), 32'hA5);
        check_val("t1_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd0);
        drain_and_check("t1");

        // 2: bad parity
        send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0);
        #1;
        check_val("t2_perr", 32'(parity_err), 32'd1);
        check_val("t2_ferr", 32'(frame_err), 32'd0);
        check_val("t2_valid", 32'(msg_valid), 32'd0);
        @(negedge clock);
        #1;
        check_val("t2_perr_1cyc", 32'(parity_err), 32'd0);
        check_val("t2_busy", 32'(busy), 32'd0);

        // 3: stop bit low, bad parity too, then a good frame
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        #1;
        check_val("t3_ferr", 32'(frame_err), 32'd1);
        check_val("t3_perr", 32'(parity_err), 32'd0);
        check_val("t3_valid", 32'(msg_valid), 32'd0);
        sb_q.push_back(8'h01);
        send_frame(8'h01, 1'b0, 1'b1, 2, 1'b0);
        #1;
        check_val("t3_next_valid", 32'(msg_valid), 32'd1);
        drain_and_check("t3");

        // 4: fill with consumer stalled, fifth frame overruns
        @(negedge clock);
        msg_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i), 1'b0, 1'b1, 0, 1'b0);
            #1;
            check_val("t4_no_ovr", 32'(overrun), 32'd0);
        end
        send_frame(8'h14, 1'b0, 1'b1, 0, 1'b0);
        #1;
        check_val("t4_ovr", 32'(overrun), 32'd1);
        check_val("t4_head", 32'(msg_data), 32'h10);
        @(negedge clock);
        #1;
        check_val("t4_ovr_1cyc", 32'(overrun), 32'd0);
        @(negedge clock);
        msg_ready = 1'b1;
        drain_and_check("t4");

        // 5: full FIFO, pop coincides with stop strobe
        @(negedge clock);
        msg_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(8'(8'h20 + i));
            send_frame(8'(8'h20 + i), 1'b0, 1'b1, 0, 1'b0);
        end
        sb_q.push_back(8'h24);
        send_frame(8'h24, 1'b0, 1'b1, 0, 1'b1);
        #1;
        check_val("t5_no_ovr", 32'(overrun), 32'd0);
        check_val("t5_valid", 32'(msg_valid), 32'd1);
        check_val("t5_head", 32'(msg_data), 32'h21);
        check_val("t5_sb_depth", 32'(sb_q.size()), 32'd4);
        @(negedge clock);
        msg_ready = 1'b1;
        drain_and_check("t5");

        // 6: reset mid-frame with a message pending
        @(negedge clock);
        msg_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 0, 1'b0);
        #1;
        check_val("t6_pending", 32'(msg_valid), 32'd1);
        send_bit(1'b0, 3);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 3);
        check_val("t6_busy_mid", 32'(busy), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_valid", 32'(msg_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        msg_ready = 1'b1;
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
        #1;
        check_val("t6_after_valid", 32'(msg_valid), 32'd1);
        drain_and_check("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
